scan_seq: RTL and testbench

SCAN_SEQ -- requirements
Module: scan_seq

---
 rtl/scan_pkg.sv | 13 +
 rtl/mux_7.sv | 16 +
 rtl/scan_seq.sv | 115 +++++++++++
 tb/tb_scan_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
// Imported by the sequencer top.
package scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int         NCH     = 7;
  localparam logic [2:0] LAST_CH = 3'd6;

endpackage

// File: rtl/mux_7.sv
// 7:1 single-bit mux; selects outside 0..6 read as 0.
// Combinational leaf used by the scan sequencer.
module mux_7 (
  input  logic [6:0] d_i,
  input  logic [3:0] sel_i,
  output logic       y_o
);

  always_comb begin
    y_o = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (sel_i == 4'(i)) y_o = d_i[i];
    end
  end

endmodule

// File: rtl/scan_seq.sv
// Sweeps 7 channels through mux_7, dwelling DWELL cycles on each,
// and publishes the captured sweep as a 7-bit word.
module scan_seq
  import scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  input  logic [6:0] a,
  output logic [2:0] sel,
  output logic       busy,
  output logic [6:0] word,
  output logic       done,
  output logic [7:0] sweep_cnt
);

  localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);

  state_t           state_q;
  logic [2:0]       sel_q;
  logic [3:0]       dwell_q;
  logic [NCH-1:0]   shadow_q;
  logic [NCH-1:0]   shadow_d;
  logic [NCH-1:0]   word_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       cnt_q;
  logic             mux_y;
  logic             last_dwell;

  mux_7 u_mux (
    .d_i   (a),
    .sel_i ({1'b0, sel_q}),
    .y_o   (mux_y)
  );

  assign last_dwell = (dwell_q == DWELL_M1);

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q == 3'(i)) shadow_d[i] = mux_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      dwell_q  <= 4'd0;
      shadow_q <= '0;
      word_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q  <= SCAN;
            busy_q   <= 1'b1;
            sel_q    <= 3'd0;
            dwell_q  <= 4'd0;
            shadow_q <= '0;
          end
        end
        SCAN: begin
          // abort wins even over the final sample
          if (abort) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            sel_q    <= 3'd0;
            dwell_q  <= 4'd0;
            shadow_q <= '0;
          end else if (last_dwell) begin
            dwell_q <= 4'd0;
            if (sel_q == LAST_CH) begin
              word_q   <= shadow_d;
              done_q   <= 1'b1;
              cnt_q    <= cnt_q + 8'd1;
              sel_q    <= 3'd0;
              shadow_q <= '0;
              if (!cont) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              shadow_q <= shadow_d;
              sel_q    <= sel_q + 3'd1;
            end
          end else begin
            dwell_q <= dwell_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sel_q   <= 3'd0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign word      = word_q;
  assign done      = done_q;
  assign sweep_cnt = cnt_q;

endmodule

// File: tb/tb_scan_seq.sv
// Directed bench for scan_seq: vector table for a DWELL=2 sweep,
// then hand sequences for cont, abort, reset and DWELL=1 wrap.
module tb_scan_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s2, c2, ab2;
  logic [6:0] a2;
  logic [2:0] sel2;
  logic       busy2, done2;
  logic [6:0] word2;
  logic [7:0] cnt2;

  logic       s1, c1, ab1;
  logic [6:0] a1;
  logic [2:0] sel1;
  logic       busy1, done1;
  logic [6:0] word1;
  logic [7:0] cnt1;

  scan_seq #(.DWELL(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .start(s2), .cont(c2), .abort(ab2), .a(a2),
    .sel(sel2), .busy(busy2), .word(word2),
    .done(done2), .sweep_cnt(cnt2)
  );

  scan_seq #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start(s1), .cont(c1), .abort(ab1), .a(a1),
    .sel(sel1), .busy(busy1), .word(word1),
    .done(done1), .sweep_cnt(cnt1)
  );

  typedef struct {
    logic       st;
    logic       ab;
    logic [6:0] a;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic [6:0] word;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 7'h53, 3'd0, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 7'h52, 3'd0, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 7'h53, 3'd1, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 7'h53, 3'd1, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 7'h53, 3'd2, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 7'h53, 3'd2, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 7'h53, 3'd3, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 7'h53, 3'd3, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 7'h53, 3'd4, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 7'h53, 3'd4, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[10] = '{1'b0, 1'b0, 7'h53, 3'd5, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 7'h53, 3'd5, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[12] = '{1'b0, 1'b0, 7'h53, 3'd6, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 7'h53, 3'd6, 1'b1, 1'b0, 7'h00, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 7'h53, 3'd0, 1'b0, 1'b1, 7'h53, 8'd1};
    tbl[15] = '{1'b0, 1'b0, 7'h53, 3'd0, 1'b0, 1'b0, 7'h53, 8'd1};

    rst_n = 1'b0;
    s2 = 0; c2 = 0; ab2 = 0; a2 = '0;
    s1 = 0; c1 = 0; ab1 = 0; a1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_sel2",  32'(sel2),  0);
    chk("rst_busy2", 32'(busy2), 0);
    chk("rst_done2", 32'(done2), 0);
    chk("rst_word2", 32'(word2), 0);
    chk("rst_cnt2",  32'(cnt2),  0);
    chk("rst_busy1", 32'(busy1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      s2 = tbl[i].st; ab2 = tbl[i].ab; a2 = tbl[i].a;
      step();
      chk($sformatf("v%0d_sel", i),  32'(sel2),  32'(tbl[i].sel));
      chk($sformatf("v%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(done2), 32'(tbl[i].done));
      chk($sformatf("v%0d_word", i), 32'(word2), 32'(tbl[i].word));
      chk($sformatf("v%0d_cnt", i),  32'(cnt2),  32'(tbl[i].cnt));
    end
    s2 = 0;

    s2 = 1; c2 = 1; a2 = 7'h00;
    step();
    s2 = 0;
    chk("cont_busy0", 32'(busy2), 1);
    for (int k = 1; k <= 35; k++) begin
      step();
      chk($sformatf("cont_done%0d", k), 32'(done2),
          32'(k == 14 || k == 28));
      chk($sformatf("cont_busy%0d", k), 32'(busy2), 1);
      if (k == 14) begin
        chk("cont_w00", 32'(word2), 32'h00);
        chk("cont_c2",  32'(cnt2),  2);
        a2 = 7'h7F;
      end
      if (k == 28) begin
        chk("cont_w7f", 32'(word2), 32'h7F);
        chk("cont_c3",  32'(cnt2),  3);
      end
    end
    chk("ab_presel", 32'(sel2), 3);
    ab2 = 1;
    step();
    ab2 = 0;
    chk("ab_sel",  32'(sel2),  0);
    chk("ab_busy", 32'(busy2), 0);
    chk("ab_done", 32'(done2), 0);
    chk("ab_word", 32'(word2), 32'h7F);
    chk("ab_cnt",  32'(cnt2),  3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab_nodone", 32'(done2), 0);
      chk("ab_idle",   32'(busy2), 0);
    end
    s2 = 1; ab2 = 1;
    step();
    chk("abst_idle", 32'(busy2), 0);
    s2 = 0; ab2 = 0; c2 = 0;

    s2 = 1; a2 = 7'h55;
    step();
    s2 = 0;
    for (int k = 1; k <= 13; k++) step();
    chk("abl_sel6", 32'(sel2), 6);
    ab2 = 1;
    step();
    ab2 = 0;
    chk("abl_done", 32'(done2), 0);
    chk("abl_cnt",  32'(cnt2),  3);
    chk("abl_word", 32'(word2), 32'h7F);
    chk("abl_busy", 32'(busy2), 0);
    step();
    chk("abl_done2", 32'(done2), 0);

    s2 = 1;
    step();
    s2 = 0;
    for (int k = 1; k <= 8; k++) step();
    chk("rs_sel4", 32'(sel2), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_sel",  32'(sel2),  0);
    chk("rs_busy", 32'(busy2), 0);
    chk("rs_done", 32'(done2), 0);
    chk("rs_word", 32'(word2), 0);
    chk("rs_cnt",  32'(cnt2),  0);
    @(negedge clk);
    rst_n = 1'b1;
    s2 = 1;
    step();
    s2 = 0;
    chk("rs_start", 32'(busy2), 1);
    chk("rs_sel0",  32'(sel2),  0);
    ab2 = 1;
    step();
    ab2 = 0;
    chk("rs_ab_busy", 32'(busy2), 0);
    chk("rs_ab_cnt",  32'(cnt2),  0);

    s1 = 1; c1 = 1; a1 = 7'h2A;
    step();
    s1 = 0;
    chk("d1_sel0",  32'(sel1),  0);
    chk("d1_busy0", 32'(busy1), 1);
    for (int k = 1; k <= 1792; k++) begin
      step();
      chk($sformatf("d1_sel%0d", k), 32'(sel1), 32'(k % 7));
      chk($sformatf("d1_done%0d", k), 32'(done1),
          32'(k % 7 == 0));
      if (k == 1785) chk("d1_c255", 32'(cnt1), 255);
    end
    chk("d1_wrap", 32'(cnt1),  0);
    chk("d1_word", 32'(word1), 32'h2A);
    chk("d1_busy", 32'(busy1), 1);
    c1 = 0;
    for (int k = 1; k <= 7; k++) step();
    chk("d1_end_done", 32'(done1), 1);
    chk("d1_end_busy", 32'(busy1), 0);
    chk("d1_end_cnt",  32'(cnt1),  1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
